// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: bit-serial modular exponentiation, result = base^exponent mod modulus.
// Left-to-right square-and-multiply. Each modular multiply is an interleaved
// shift-and-subtract loop that takes one radix-2 step per clock, WIDTH clocks per multiply.
module rsa_modexp_core #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, REDUCE, SQUARE, MULT, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     base_q;   // latched message operand
  logic [EXP_WIDTH-1:0] exp_q;    // latched exponent
  logic [WIDTH-1:0]     mod_q;    // latched modulus n
  logic [WIDTH-1:0]     m_q;      // base mod n
  logic [WIDTH-1:0]     r_q;      // running result R
  logic [WIDTH-1:0]     p_q;      // modmul accumulator, always < n between steps
  logic [CW-1:0]        cnt_q;    // multiplier bit being consumed in this phase
  logic [IW-1:0]        idx_q;    // exponent bit being processed

  logic [WIDTH-1:0]     a_sel;
  logic [WIDTH-1:0]     b_sel;
  logic [WIDTH+1:0]     n_ext;
  logic [WIDTH+1:0]     p_dbl;
  logic [WIDTH+1:0]     p_red;
  logic [WIDTH+1:0]     p_add;
  logic [WIDTH-1:0]     p_next;

  // One modmul step: operand selection per phase, then P=2P, reduce, add a if b[i], reduce.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    a_sel = r_q;
    b_sel = m_q;
    case (state)
      REDUCE: begin
        a_sel = WIDTH'(1);
        b_sel = base_q;
      end
      SQUARE:  b_sel = r_q;
      default: ;
    endcase
    n_ext  = {2'b00, mod_q};
    p_dbl  = {1'b0, p_q, 1'b0};
    p_red  = (p_dbl >= n_ext) ? p_dbl - n_ext : p_dbl;
    p_add  = b_sel[cnt_q] ? p_red + {2'b00, a_sel} : p_red;
    p_next = (p_add >= n_ext) ? WIDTH'(p_add - n_ext) : WIDTH'(p_add);
  end

  // Control FSM and datapath registers; outputs are registered and change only on entry to DONE or on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      base_q <= '0;
      exp_q  <= '0;
      mod_q  <= '0;
      m_q    <= '0;
      r_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_q <= base;
            exp_q  <= exponent;
            mod_q  <= modulus;
            err    <= 1'b0;
            idx_q  <= IDX_TOP;
            cnt_q  <= CNT_TOP;
            p_q    <= '0;
            if (modulus == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              err    <= 1'b1;
              result <= '0;
            end else if (modulus == WIDTH'(1)) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= '0;
            end else begin
              state <= REDUCE;
              busy  <= 1'b1;
            end
          end
        end

        REDUCE, SQUARE, MULT: begin
          p_q   <= p_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // Phase complete: restart the accumulator and pick the next phase.
            p_q   <= '0;
            cnt_q <= CNT_TOP;
            if (state == REDUCE) begin
              m_q   <= p_next;
              r_q   <= WIDTH'(1);
              state <= SQUARE;
            end else begin
              r_q <= p_next;
              if (state == SQUARE && exp_q[idx_q]) begin
                state <= MULT;
              end else if (idx_q == '0) begin
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= p_next;
              end else begin
                idx_q <= idx_q - 1'b1;
                state <= SQUARE;
              end
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
